mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Two-client arbiter sitting directly upstream of the single-port virtual memory (DPI pmem model).
//   Accepts read requests from the IFU and read/write requests from the LSU over valid/ready.
//   Serialises them onto one memory port: one outstanding transaction at a time, round-robin grant.
//   Returns each result to its owner with an error flag; a watchdog terminates hung reads.
// PARAMETERS
//   ADDR_W   32   address width, all request and memory address ports
//   DATA_W   64   data width, all data ports; write mask width is DATA_W/8
//   TIMEOUT  255  max cycles spent in WAIT before a read is aborted with error; must be >= 2
// PORTS
//   clock        in   1        system clock, all state on rising edge
//   reset        in   1        asynchronous, active-low reset
//   ifu_valid    in   1        IFU read request valid
//   ifu_ready    out  1        IFU request accepted this cycle (valid&ready)
//   ifu_addr     in   ADDR_W   IFU read address
//   ifu_rvalid   out  1        IFU response valid, one-cycle pulse
//   ifu_rdata    out  DATA_W   IFU response data
//   ifu_err      out  1        IFU response error (timeout), qualified by ifu_rvalid
//   lsu_valid    in   1        LSU request valid
//   lsu_ready    out  1        LSU request accepted this cycle
//   lsu_wen      in   1        1 = write, 0 = read
//   lsu_addr     in   ADDR_W   LSU address
//   lsu_wdata    in   DATA_W   LSU write data
//   lsu_wmask    in   DATA_W/8 LSU byte write mask
//   lsu_rvalid   out  1        LSU response valid (read data or write ack), one-cycle pulse
//   lsu_rdata    out  DATA_W   LSU read data; 0 for write acks
//   lsu_err      out  1        LSU response error (timeout), qualified by lsu_rvalid
//   mem_ren      out  1        memory read enable, registered, one-cycle pulse
//   mem_wen      out  1        memory write enable, registered, one-cycle pulse
//   mem_addr     out  ADDR_W   memory address, registered, held stable from ISSUE until next grant
//   mem_wdata    out  DATA_W   memory write data, registered
//   mem_wmask    out  DATA_W/8 memory write mask, registered
//   mem_rvalid   in   1        memory read data valid (one cycle after mem_ren)
//   mem_rdata    in   DATA_W   memory read data, sampled only when mem_rvalid=1
// BEHAVIOUR
//   States: IDLE -> ISSUE -> (read) WAIT -> RESP -> IDLE; (write) ISSUE -> RESP -> IDLE.
//   IDLE: ready asserted only here, to at most one client; ifu_ready/lsu_ready are never both 1.
//     Grant: single valid client wins. Both valid: client not in last_grant wins; last_grant updates on accept.
//     Accept: latch owner, addr, wen, wdata, wmask. Go to ISSUE. IFU requests are always reads.
//   ISSUE (1 cycle): mem_ren=~wen or mem_wen=wen, driven for exactly this cycle. Read -> WAIT, write -> RESP.
//   WAIT: watchdog counter cleared on entry, +1 per cycle.
//     mem_rvalid=1 -> latch mem_rdata, err=0, go to RESP.
//     Counter reaches TIMEOUT-1 without mem_rvalid -> data=0, err=1, go to RESP.
//     If both occur in the same cycle, mem_rvalid wins.
//   RESP (1 cycle): owner's *_rvalid=1 with latched data/err; other client's rvalid=0. Go to IDLE.
//   Responses have no backpressure; clients must accept the rvalid pulse.
//   Latency from accept at cycle 0, with a 1-cycle memory:
//     read: mem_ren @1, mem_rvalid @2, *_rvalid @3.
//     write: mem_wen @1, lsu_rvalid (ack, rdata=0) @2.
//     Back-to-back throughput: next accept in the first IDLE cycle after RESP.
//   Clients must hold addr/wdata/wmask/wen stable while valid && !ready.
//   mem_rvalid outside WAIT is ignored and must not alter any state.
//   Reset (async assert, any state): state=IDLE, last_grant=LSU (IFU wins first tie), counter=0.
//     All outputs to 0; any in-flight transaction is dropped with no response.
//   Width: counter is $clog2(TIMEOUT+1) bits, saturating, never wraps.
// TESTING
//   1 IFU read 0x8000_0000; memory returns 0x1122334455667788 -> mem_ren @1, ifu_rvalid @3 with that data, err=0.
//   2 LSU write 0x8000_0010, wdata 0xDEAD_BEEF, mask 0x0F -> mem_wen @1 with identical addr/data/mask, lsu_rvalid @2, rdata=0.
//   3 Both clients valid continuously out of reset -> grants alternate IFU,LSU,IFU,LSU; ready never both 1.
//   4 Read with memory silent (TIMEOUT=8) -> rvalid with err=1, data=0 exactly 8 WAIT cycles after entry; next request then served normally.
//   5 Assert reset in WAIT -> all outputs 0 immediately (async); no response issued; first post-reset tie goes to IFU.
//   6 Spurious mem_rvalid in IDLE with data 0xFF..FF -> no *_rvalid pulse; next read returns its own data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin IFU/LSU arbiter that serialises one transaction at a time onto a
// single-port memory and aborts reads that the memory never answers.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_valid,
  output logic                ifu_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_lsu_q, owner_lsu_d;
  logic                last_lsu_q, last_lsu_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_pulse_q, rd_pulse_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic                ifu_gnt, lsu_gnt;

  // On a tie the client that was not granted last time wins.
  always_comb begin
    ifu_gnt   = ifu_valid && (!lsu_valid || last_lsu_q);
    lsu_gnt   = lsu_valid && !ifu_gnt;
    ifu_ready = reset && (state_q == S_IDLE) && ifu_gnt;
    lsu_ready = reset && (state_q == S_IDLE) && lsu_gnt;
  end

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    last_lsu_d  = last_lsu_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rd_pulse_d  = 1'b0;
    wr_pulse_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_ready || lsu_ready) begin
          owner_lsu_d = lsu_ready;
          last_lsu_d  = lsu_ready;
          wen_d       = lsu_ready && lsu_wen;
          addr_d      = lsu_ready ? lsu_addr : ifu_addr;
          wdata_d     = lsu_ready ? lsu_wdata : '0;
          wmask_d     = lsu_ready ? lsu_wmask : '0;
          rdata_d     = '0;
          err_d       = 1'b0;
          rd_pulse_d  = !(lsu_ready && lsu_wen);
          wr_pulse_d  = lsu_ready && lsu_wen;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = wen_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        // Data arriving on the last watchdog cycle still counts as a good read.
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      last_lsu_q  <= 1'b1;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rd_pulse_q  <= 1'b0;
      wr_pulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      last_lsu_q  <= last_lsu_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rd_pulse_q  <= rd_pulse_d;
      wr_pulse_q  <= wr_pulse_d;
    end
  end

  always_comb begin
    ifu_rvalid = (state_q == S_RESP) && !owner_lsu_q;
    lsu_rvalid = (state_q == S_RESP) && owner_lsu_q;
    ifu_rdata  = ifu_rvalid ? rdata_q : '0;
    lsu_rdata  = lsu_rvalid ? rdata_q : '0;
    ifu_err    = ifu_rvalid && err_q;
    lsu_err    = lsu_rvalid && err_q;
    mem_ren    = rd_pulse_q;
    mem_wen    = wr_pulse_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_wmask  = wmask_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing model plus a reactive
// memory, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ifu_valid = 1'b0, ifu_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_rvalid, ifu_err;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_valid = 1'b0, lsu_ready, lsu_wen = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_rvalid, lsu_err;
  logic [DW-1:0] lsu_rdata;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stimulus knobs
  int            dly_force = 1;
  logic          fixed_en = 1'b0;
  logic [DW-1:0] fixed_data = '0;
  logic          rand_spur = 1'b0;

  // Transaction model: one in flight, timing from accept cycle
  logic          m_busy = 1'b0, m_lsu = 1'b0, m_wen = 1'b0, m_err = 1'b0;
  logic          m_last_lsu = 1'b1, m_ifu_acc = 1'b0, m_lsu_acc = 1'b0;
  int            m_acc = 0, m_resp = 0, m_delay = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_data = '0;
  logic [MW-1:0] m_wmask = '0;

  // Memory responder schedule
  logic          mem_pend = 1'b0;
  int            mem_at = 0;
  logic [AW-1:0] mem_a = '0;

  function automatic logic [DW-1:0] memdata(input logic [AW-1:0] a);
    if (fixed_en) return fixed_data;
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic e_ir, e_lr, e_ren, e_wen, resp;
    int d;
    if (!reset) begin
      chk("rst_ifu_ready", ifu_ready, 0);
      chk("rst_lsu_ready", lsu_ready, 0);
      chk("rst_ifu_rvalid", ifu_rvalid, 0);
      chk("rst_lsu_rvalid", lsu_rvalid, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_addr", mem_addr, 0);
      m_busy = 0; m_last_lsu = 1; m_addr = '0; m_wdata = '0; m_wmask = '0;
      m_ifu_acc = 0; m_lsu_acc = 0; mem_pend = 0;
    end else begin
      e_ir  = !m_busy && ifu_valid && (!lsu_valid || m_last_lsu);
      e_lr  = !m_busy && lsu_valid && !e_ir;
      e_ren = m_busy && !m_wen && (cyc == m_acc + 1);
      e_wen = m_busy && m_wen && (cyc == m_acc + 1);
      resp  = m_busy && (cyc == m_resp);
      chk("ifu_ready", ifu_ready, e_ir);
      chk("lsu_ready", lsu_ready, e_lr);
      chk("mem_ren", mem_ren, e_ren);
      chk("mem_wen", mem_wen, e_wen);
      chk("mem_addr", mem_addr, m_addr);
      if (e_wen) begin
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
      end
      chk("ifu_rvalid", ifu_rvalid, resp && !m_lsu);
      chk("lsu_rvalid", lsu_rvalid, resp && m_lsu);
      if (resp && !m_lsu) begin
        chk("ifu_rdata", ifu_rdata, m_data);
        chk("ifu_err", ifu_err, m_err);
      end
      if (resp && m_lsu) begin
        chk("lsu_rdata", lsu_rdata, m_data);
        chk("lsu_err", lsu_err, m_err);
      end
      // memory reacts to what the DUT actually issued
      if (mem_ren && m_delay <= TO) begin
        mem_pend = 1; mem_at = cyc + m_delay; mem_a = mem_addr;
      end
      m_ifu_acc = e_ir;
      m_lsu_acc = e_lr;
      if (resp) m_busy = 0;
      if (e_ir || e_lr) begin
        m_busy = 1; m_acc = cyc; m_lsu = e_lr; m_last_lsu = e_lr;
        m_wen  = e_lr && lsu_wen;
        m_addr = e_lr ? lsu_addr : ifu_addr;
        if (m_wen) begin
          m_wdata = lsu_wdata; m_wmask = lsu_wmask;
          m_resp = cyc + 2; m_data = '0; m_err = 0;
        end else begin
          if (dly_force >= 0) d = dly_force;
          else begin
            case ($urandom_range(9))
              0, 1, 2, 3, 4, 5: d = 1;
              6, 7:             d = $urandom_range(2, TO - 1);
              8:                d = TO;
              default:          d = TO + 5;
            endcase
          end
          m_delay = d;
          if (d <= TO) begin m_resp = cyc + 2 + d; m_data = memdata(m_addr); m_err = 0; end
          else begin m_resp = cyc + 2 + TO; m_data = '0; m_err = 1; end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (mem_pend && cyc == mem_at) begin
      mem_rvalid = 1; mem_rdata = memdata(mem_a);
    end else if (rand_spur && !(mem_pend && cyc <= mem_at) &&
                 !(m_busy && !m_wen && cyc >= m_acc + 2) && $urandom_range(9) == 0) begin
      mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
    end else begin
      mem_rvalid = 0; mem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic rand_clients();
    if (!ifu_valid || m_ifu_acc) begin
      ifu_valid = ($urandom_range(2) != 0);
      ifu_addr  = $urandom;
    end
    if (!lsu_valid || m_lsu_acc) begin
      lsu_valid = ($urandom_range(2) != 0);
      lsu_wen   = $urandom_range(1);
      lsu_addr  = $urandom;
      lsu_wdata = {$urandom, $urandom};
      lsu_wmask = $urandom_range(255);
    end
  endtask

  task automatic drain();
    int k = 0;
    ifu_valid = 0; lsu_valid = 0;
    while (m_busy && k < 40) begin step(); k++; end
    n_tests++;
    if (m_busy) begin
      n_fail++;
      $display("FAIL drain_timeout @cycle %0d: got busy expected idle", cyc);
    end
  endtask

  logic grant_seq [4];
  int   gcount;

  initial begin
    #2 reset = 0;
    repeat (3) step();
    reset = 1;

    // 1: IFU read with 1-cycle memory
    fixed_en = 1; fixed_data = 64'h1122_3344_5566_7788; dly_force = 1;
    step(); ifu_valid = 1; ifu_addr = 32'h8000_0000;
    @(negedge clock); chk("t1_ready", ifu_ready, 1);
    step(); ifu_valid = 0;
    @(negedge clock); chk("t1_mem_ren", mem_ren, 1); chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    step(); @(negedge clock); chk("t1_early_rvalid", ifu_rvalid, 0);
    step(); @(negedge clock);
    chk("t1_rvalid", ifu_rvalid, 1);
    chk("t1_rdata", ifu_rdata, 64'h1122_3344_5566_7788);
    chk("t1_err", ifu_err, 0);
    step(); fixed_en = 0;

    // 2: LSU write
    lsu_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    @(negedge clock); chk("t2_ready", lsu_ready, 1);
    step(); lsu_valid = 0;
    @(negedge clock);
    chk("t2_mem_wen", mem_wen, 1); chk("t2_mem_ren", mem_ren, 0);
    chk("t2_mem_addr", mem_addr, 32'h8000_0010);
    chk("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("t2_mem_wmask", mem_wmask, 8'h0F);
    step(); @(negedge clock);
    chk("t2_rvalid", lsu_rvalid, 1); chk("t2_rdata", lsu_rdata, 0); chk("t2_err", lsu_err, 0);

    // 4: silent memory -> timeout TO cycles after WAIT entry
    step(); lsu_wen = 0; dly_force = 99; ifu_valid = 1; ifu_addr = 32'h8000_0100;
    @(negedge clock); chk("t4_ready", ifu_ready, 1);
    step(); ifu_valid = 0;
    for (int i = 0; i < TO; i++) begin
      step(); @(negedge clock); chk("t4_no_rvalid", ifu_rvalid, 0);
    end
    step(); @(negedge clock);
    chk("t4_rvalid", ifu_rvalid, 1); chk("t4_err", ifu_err, 1); chk("t4_rdata", ifu_rdata, 0);
    dly_force = 1;
    step(); lsu_valid = 1; lsu_wen = 0; lsu_addr = 32'h0000_1000;
    @(negedge clock); chk("t4_next_ready", lsu_ready, 1);
    step(); lsu_valid = 0;
    step(); step(); @(negedge clock);
    chk("t4_next_rvalid", lsu_rvalid, 1);
    chk("t4_next_rdata", lsu_rdata, 64'h5A5A_D3C3_FFFF_EFFF);
    chk("t4_next_err", lsu_err, 0);

    // 5: async reset during WAIT
    dly_force = 99;
    step(); ifu_valid = 1; ifu_addr = 32'h8000_0200;
    @(negedge clock); chk("t5_ready", ifu_ready, 1);
    step(); ifu_valid = 0;
    step(); step();
    @(negedge clock);
    #2; ifu_valid = 1; lsu_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0300; reset = 0;
    #1;
    chk("t5_ifu_ready", ifu_ready, 0); chk("t5_lsu_ready", lsu_ready, 0);
    chk("t5_ifu_rvalid", ifu_rvalid, 0); chk("t5_lsu_rvalid", lsu_rvalid, 0);
    chk("t5_ifu_rdata", ifu_rdata, 0); chk("t5_ifu_err", ifu_err, 0);
    chk("t5_mem_ren", mem_ren, 0); chk("t5_mem_wen", mem_wen, 0);
    chk("t5_mem_addr", mem_addr, 0); chk("t5_mem_wdata", mem_wdata, 0);
    chk("t5_mem_wmask", mem_wmask, 0);
    dly_force = 1;
    step(); step(); reset = 1;
    @(negedge clock);
    chk("t5_tie_ifu", ifu_ready, 1); chk("t5_tie_lsu", lsu_ready, 0);

    // 3: both valid continuously -> alternating grants
    gcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (gcount < 4) begin
        if (ifu_ready) begin grant_seq[gcount] = 1'b0; gcount++; end
        else if (lsu_ready) begin grant_seq[gcount] = 1'b1; gcount++; end
      end
      step();
      if (m_ifu_acc) ifu_addr = $urandom;
      if (m_lsu_acc) begin
        lsu_wen = $urandom_range(1); lsu_addr = $urandom;
        lsu_wdata = {$urandom, $urandom}; lsu_wmask = $urandom_range(255);
      end
      @(negedge clock);
    end
    chk("t3_grant_count", gcount, 4);
    chk("t3_grant0", grant_seq[0], 0);
    chk("t3_grant1", grant_seq[1], 1);
    chk("t3_grant2", grant_seq[2], 0);
    chk("t3_grant3", grant_seq[3], 1);
    step(); drain();

    // 6: spurious mem_rvalid while idle
    mem_rvalid = 1; mem_rdata = '1;
    @(negedge clock); chk("t6_ifu_rvalid", ifu_rvalid, 0); chk("t6_lsu_rvalid", lsu_rvalid, 0);
    step(); @(negedge clock); chk("t6_ifu_rvalid2", ifu_rvalid, 0); chk("t6_lsu_rvalid2", lsu_rvalid, 0);
    step(); ifu_valid = 1; ifu_addr = 32'h0000_2000;
    @(negedge clock); chk("t6_ready", ifu_ready, 1);
    step(); ifu_valid = 0;
    step(); step(); @(negedge clock);
    chk("t6_rvalid", ifu_rvalid, 1);
    chk("t6_rdata", ifu_rdata, 64'h5A5A_E3C3_FFFF_DFFF);
    chk("t6_err", ifu_err, 0);

    // random traffic with varied memory latency, timeouts and spurious data
    dly_force = -1; rand_spur = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_clients();
    end
    drain();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
